systolic_array_ctrl: RTL and testbench

Sequencing controller that sits between the host operand/result streams and the N×N `systolic_array`. For each command it does four things:
- accepts K reduction steps, one A column and one B row per step;
- applies the diagonal input skew and drives the array's `x_in`/`w_in`/`start`;
- flushes the wavefront through the array;
- reads the N result rows back through `y_index` onto a valid/ready result stream.

It honours the array's `stall` output at all times.

---
 rtl/systolic_array_ctrl.sv | 143 ++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: skews operand steps into an NxN systolic array, drains the wavefront and streams result rows out
module systolic_array_ctrl #(
    parameter int N  = 4,
    parameter int KW = 16,
    parameter int W  = 16
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [KW-1:0]                    cmd_k,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [N*W-1:0]                   op_x,
    input  logic [N*W-1:0]                   op_w,
    output logic [N*W-1:0]                   arr_x,
    output logic [N*W-1:0]                   arr_w,
    output logic                             arr_start,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] arr_y_index,
    input  logic [N*W-1:0]                   arr_y,
    input  logic                             arr_stall,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [N*W-1:0]                   res_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] res_row,
    output logic                             res_last,
    output logic                             busy,
    output logic                             done
);
    localparam int IW      = (N > 1) ? $clog2(N) : 1;
    localparam int DRAIN_N = 3 * N - 2;
    localparam int DW      = $clog2(DRAIN_N + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, READ} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] step_q, step_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [IW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          start_q;
    logic          advance;

    assign advance     = !arr_stall && ((state_q == FEED && op_valid) || state_q == DRAIN);
    assign cmd_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign op_ready    = state_q == FEED && !arr_stall;
    assign res_valid   = state_q == READ;
    assign res_last    = state_q == READ && row_q == IW'(N - 1);
    assign res_row     = row_q;
    assign arr_y_index = row_q;
    assign res_data    = arr_y;
    assign arr_start   = start_q;
    assign done        = done_q;

    // state, counters and the registered start/done strobes
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            step_q  <= '0;
            drain_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            step_q  <= step_d;
            drain_q <= drain_d;
            row_q   <= row_d;
            done_q  <= done_d;
            start_q <= advance;
        end
    end

    // sequencing: accept command, count K steps, count 3N-2 drain advances, hand out N rows
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        step_d  = step_q;
        drain_d = drain_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                k_d     = cmd_k;
                step_d  = '0;
                row_d   = '0;
                state_d = (cmd_k != '0) ? FEED : READ;
            end
            FEED: if (advance) begin
                step_d = step_q + 1'b1;
                if (step_q == k_q - 1'b1) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: if (advance) begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DW'(DRAIN_N - 1)) begin
                    state_d = READ;
                    row_d   = '0;
                end
            end
            READ: if (res_ready) begin
                if (row_q == IW'(N - 1)) begin
                    state_d = IDLE;
                    row_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] x_q [0:i];
        logic [W-1:0] w_q [0:i];
        // lane i delays its operand by i extra stages; the head loads the operand while feeding, zero while draining
        always_ff @(posedge clk) begin
            if (n_rst) begin
                for (int d = 0; d <= i; d++) begin
                    x_q[d] <= '0;
                    w_q[d] <= '0;
                end
            end else if (advance) begin
                x_q[0] <= (state_q == FEED) ? op_x[i*W +: W] : '0;
                w_q[0] <= (state_q == FEED) ? op_w[i*W +: W] : '0;
                for (int d = 1; d <= i; d++) begin
                    x_q[d] <= x_q[d-1];
                    w_q[d] <= w_q[d-1];
                end
            end
        end
        assign arr_x[i*W +: W] = x_q[i];
        assign arr_w[i*W +: W] = w_q[i];
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl: random and directed checking of the controller against a behavioural model and an array stand-in
module tb_systolic_array_ctrl;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int KW = 4;
    localparam int IW = 2;
    localparam int DR = 3 * N - 2;

    logic clk = 0, n_rst = 1, cmd_valid = 0, op_valid = 0, arr_stall = 0, res_ready = 0;
    logic [KW-1:0] cmd_k = '0;
    logic [N*W-1:0] op_x = '0, op_w = '0, arr_x, arr_w, arr_y, res_data;
    logic cmd_ready, op_ready, arr_start, res_valid, res_last, busy, done;
    logic [IW-1:0] arr_y_index, res_row;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    systolic_array_ctrl #(.N(N), .KW(KW), .W(W)) dut (
        .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
        .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_w(op_w),
        .arr_x(arr_x), .arr_w(arr_w), .arr_start(arr_start), .arr_y_index(arr_y_index),
        .arr_y(arr_y), .arr_stall(arr_stall), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .res_last(res_last), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // array stand-in: records wavefronts, de-skews them and forms C = sum_k A_k^T B_k
    logic [W-1:0] sc [N][N];
    logic [N*W-1:0] sx[$], sw[$];
    logic [N*W-1:0] stx, stw;
    logic [W-1:0] sa, sb, sacc;
    int s_base, s_k;
    bit s_pend;
    for (genvar j = 0; j < N; j++) begin : g_y
        assign arr_y[j*W +: W] = sc[arr_y_index][j];
    end
    always @(negedge clk) begin
        if (n_rst) s_pend = 0;
        else begin
            if (arr_start) begin
                sx.push_back(arr_x);
                sw.push_back(arr_w);
            end
            if (cmd_valid && cmd_ready) begin
                s_base = sx.size();
                s_k = int'(cmd_k);
                s_pend = (cmd_k != '0);
            end
            if (s_pend && sx.size() == s_base + s_k + N - 1) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        sacc = '0;
                        for (int k = 0; k < s_k; k++) begin
                            stx = sx[s_base + k + i];
                            stw = sw[s_base + k + j];
                            sa = stx[i*W +: W];
                            sb = stw[j*W +: W];
                            sacc = sacc + sa * sb;
                        end
                        sc[i][j] = sacc;
                    end
                s_pend = 0;
            end
        end
    end

    // behavioural model: phase, counts, history of wavefront heads, expected product
    int ph = 0, mk = 0, nacc = 0, nd = 0, mrow = 0;
    bit start_e = 0, done_e = 0, started = 0, m_adv;
    logic [N*W-1:0] hx[$], hw[$];
    logic [W-1:0] ax [16][N];
    logic [W-1:0] aw [16][N];
    logic [W-1:0] mc [N][N];
    logic [W-1:0] macc;
    always @(posedge clk) begin
        if (n_rst) begin
            ph = 0; mrow = 0; start_e = 0; done_e = 0; started = 1;
            hx.delete(); hw.delete();
        end else begin
            m_adv = !arr_stall && ((ph == 1 && op_valid) || ph == 2);
            start_e = m_adv;
            done_e = 0;
            if (m_adv) begin
                hx.push_back(ph == 1 ? op_x : '0);
                hw.push_back(ph == 1 ? op_w : '0);
            end
            case (ph)
                0: if (cmd_valid) begin
                    mk = int'(cmd_k); nacc = 0; mrow = 0;
                    ph = (mk > 0) ? 1 : 3;
                end
                1: if (m_adv) begin
                    for (int i = 0; i < N; i++) begin
                        ax[nacc][i] = op_x[i*W +: W];
                        aw[nacc][i] = op_w[i*W +: W];
                    end
                    nacc++;
                    if (nacc == mk) begin ph = 2; nd = 0; end
                end
                2: if (m_adv) begin
                    nd++;
                    if (nd == DR) begin
                        ph = 3; mrow = 0;
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++) begin
                                macc = '0;
                                for (int k = 0; k < mk; k++) macc = macc + ax[k][i] * aw[k][j];
                                mc[i][j] = macc;
                            end
                    end
                end
                default: if (res_ready) begin
                    if (mrow == N - 1) begin ph = 0; mrow = 0; done_e = 1; end
                    else mrow++;
                end
            endcase
        end
    end

    // per-cycle comparison of every output against the model
    logic [N*W-1:0] ex, ew, tx, tw, er;
    always @(negedge clk) if (started) begin
        ex = '0; ew = '0; er = '0;
        for (int i = 0; i < N; i++) if (hx.size() - 1 - i >= 0) begin
            tx = hx[hx.size() - 1 - i];
            tw = hw[hw.size() - 1 - i];
            ex[i*W +: W] = tx[i*W +: W];
            ew[i*W +: W] = tw[i*W +: W];
        end
        check("cmd_ready", cmd_ready, ph == 0);
        check("busy", busy, ph != 0);
        check("op_ready", op_ready, ph == 1 && !arr_stall);
        check("arr_start", arr_start, start_e);
        check("done", done, done_e);
        check("res_valid", res_valid, ph == 3);
        check("res_last", res_last, ph == 3 && mrow == N - 1);
        check("arr_x", arr_x, ex);
        check("arr_w", arr_w, ew);
        if (ph == 3) begin
            for (int j = 0; j < N; j++) er[j*W +: W] = mc[mrow][j];
            check("res_row", res_row, mrow);
            check("arr_y_index", arr_y_index, mrow);
            check("res_data", res_data, er);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // identity A, B rows {1,2,3,4}+4k; optional stalls/bubbles and a hold on row 1
    task automatic run_ident(input int k, input bit bubbles, input int hold, output int lat, output int starts);
        int acc, held, rows;
        acc = 0; held = 0; rows = 0; starts = 0; lat = -1;
        res_ready = 1; arr_stall = 0; op_valid = 0;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_k = KW'(k);
        step();
        cmd_valid = 0;
        for (int n = 1; n < 200; n++) begin
            if (done) begin lat = n; break; end
            if (arr_start) starts++;
            if (res_valid) begin
                check("ident_row_order", res_row, rows);
                for (int j = 0; j < N; j++) check("ident_row_data", res_data[j*W +: W], 1 + 4 * res_row + j);
            end
            arr_stall = bubbles && ((n >= 3 && n <= 5) || n == 15 || n == 16);
            op_valid = acc < k && (!bubbles || n % 2 == 1);
            for (int i = 0; i < N; i++) begin
                op_x[i*W +: W] = (i == acc) ? 16'd1 : 16'd0;
                op_w[i*W +: W] = W'(1 + 4 * acc + i);
            end
            res_ready = !(res_valid && res_row == 1 && held < hold);
            if (!res_ready) held++;
            if (res_valid && res_ready) rows++;
            if (op_valid && !arr_stall) acc++;
            step();
        end
        op_valid = 0; arr_stall = 0; res_ready = 1;
        check("ident_rows_total", rows, 4);
    endtask

    int lat, st, dn;
    bit hs;
    initial begin
        step(); step();
        n_rst = 0;
        step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_arr_x", arr_x, 64'd0);
        check("rst_arr_start", arr_start, 1'b0);
        check("rst_op_ready", op_ready, 1'b0);
        check("rst_done", done, 1'b0);

        res_ready = 1;
        cmd_valid = 1; cmd_k = 1;
        step();
        cmd_valid = 0; op_valid = 1;
        op_x = {16'd4, 16'd3, 16'd2, 16'd1};
        op_w = {16'd8, 16'd7, 16'd6, 16'd5};
        step();
        op_valid = 0;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < N; i++) begin
                check("skew_x", arr_x[i*W +: W], (n == i) ? i + 1 : 0);
                check("skew_w", arr_w[i*W +: W], (n == i) ? i + 5 : 0);
            end
            step();
        end
        for (int n = 0; n < 100 && !cmd_ready; n++) step();

        run_ident(4, 0, 0, lat, st);
        check("ident_latency", lat, 19);
        check("ident_starts", st, 14);
        run_ident(4, 0, 5, lat, st);
        check("backpressure_latency", lat, 24);
        run_ident(4, 1, 0, lat, st);
        check("stall_latency", lat, 28);
        check("stall_starts", st, 14);
        run_ident(0, 0, 0, lat, st);
        check("k0_latency", lat, 5);
        check("k0_starts", st, 0);

        cmd_valid = 1; cmd_k = 2;
        step();
        cmd_valid = 0; op_valid = 1;
        op_x = {$urandom, $urandom}; step();
        op_x = {$urandom, $urandom}; step();
        op_valid = 0;
        step(); step();
        n_rst = 1;
        step();
        check("midrst_busy", busy, 1'b0);
        check("midrst_arr_x", arr_x, 64'd0);
        check("midrst_arr_w", arr_w, 64'd0);
        check("midrst_arr_start", arr_start, 1'b0);
        check("midrst_res_valid", res_valid, 1'b0);
        check("midrst_done", done, 1'b0);
        n_rst = 0;
        dn = 0;
        repeat (30) begin step(); if (done) dn++; end
        check("midrst_no_done", dn, 0);

        for (int c = 0; c < 8000; c++) begin
            if (!cmd_valid) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 9))
                    0: cmd_k = 0;
                    1: cmd_k = 15;
                    default: cmd_k = KW'($urandom_range(1, 8));
                endcase
            end
            op_valid = ($urandom_range(0, 3) != 0);
            op_x = {$urandom, $urandom};
            op_w = {$urandom, $urandom};
            arr_stall = ($urandom_range(0, 5) == 0);
            res_ready = ($urandom_range(0, 3) != 0);
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) cmd_valid = 0;
        end
        cmd_valid = 0; op_valid = 1; arr_stall = 0; res_ready = 1;
        for (int n = 0; n < 200 && !cmd_ready; n++) step();
        check("final_idle", cmd_ready, 1'b1);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
